fcp_mst_ctrl: RTL

Synthesizable, parametrised FCP single-wire bus master. It replaces the behavioural master model in front of `fcp_core`, and adds multi-byte burst register reads and writes, a programmable UI length, and slave-response checking with error status. A host-side start/done handshake drives it. The single-wire data line is split into `d_out`/`d_oe`/`d_in`, with the pad and pull-down outside this block.

---
 rtl/fcp_mst_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fcp_mst_ctrl.sv
// fcp_mst_ctrl: FCP single-wire bus master.
// Sends a master ping, a command/address/data frame sequence, then hands the
// line to the slave. It checks the slave ping and response bytes (parity,
// ACK), sends the closing master ping and reports status to the host.
//
// Host handshake: start is a one-cycle request that is honoured only while
// busy is low and the block is idle; start in any other cycle is dropped.
// rw/addr/len/wdata are captured in the start cycle. Completion is a
// one-cycle done pulse. busy falls in that same cycle. status (and rdata
// for a successful read) hold from that done until the next one.
module fcp_mst_ctrl #(
  parameter int CLK_PER_UI  = 160,
  parameter int PING_UI     = 16,
  parameter int SLV_PING_UI = 4,
  parameter int TIMEOUT_UI  = 100,
  parameter int BURST_MAX   = 4,
  localparam int LW         = $clog2(BURST_MAX) + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   rw,
  input  logic [7:0]             addr,
  input  logic [LW-1:0]          len,
  input  logic [8*BURST_MAX-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [8*BURST_MAX-1:0] rdata,
  input  logic                   d_in,
  output logic                   d_out,
  output logic                   d_oe,
  output logic [2:0]             state_dbg
);

  localparam int PING_CYC = PING_UI * CLK_PER_UI;
  localparam int TO_CYC   = TIMEOUT_UI * CLK_PER_UI;
  localparam int SP_MIN   = (SLV_PING_UI * CLK_PER_UI) / 2;
  localparam int SP_MAX   = 2 * SLV_PING_UI * CLK_PER_UI;
  localparam int HALF_UI  = CLK_PER_UI / 2;
  localparam int TMAX     = ((PING_CYC > TO_CYC) ? PING_CYC : TO_CYC) + SP_MAX;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int UW       = $clog2(CLK_PER_UI);
  localparam int BW       = $clog2(BURST_MAX + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MPING = 3'd1,
    S_TX    = 3'd2,
    S_TURN  = 3'd3,
    S_SPING = 3'd4,
    S_RX    = 3'd5,
    S_EPING = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t                 state;
  logic                   d_s1, d_s2, d_s3;
  logic                   rise;
  logic                   rw_q;
  logic [7:0]             addr_q;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          len_eff;
  logic [8*BURST_MAX-1:0] wdata_q;
  logic [8*BURST_MAX-1:0] rbuf;
  logic [TW-1:0]          tmr;
  logic [UW-1:0]          ucnt;
  logic [3:0]             fbit;
  logic [BW-1:0]          bidx;
  logic [BW-1:0]          bidx_last;
  logic [7:0]             tx_byte;
  logic [LW-1:0]          rx_idx;
  logic                   rx_run;
  logic [8:0]             rx_sh;
  logic [1:0]             st_q;

  assign state_dbg = state;

  // Frame bit idx of byte b: 0 start(1), 1..8 data MSB first, 9 odd parity, 10 stop(0).
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [7:0] sh;
    logic       r;
    r  = 1'b0;
    sh = b << (idx - 4'd1);
    if (idx == 4'd0)       r = 1'b1;
    else if (idx <= 4'd8)  r = sh[7];
    else if (idx == 4'd9)  r = ~(^b);
    return r;
  endfunction

  // Line synchronizer plus one extra stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      d_s1 <= 1'b0;
      d_s2 <= 1'b0;
      d_s3 <= 1'b0;
    end else begin
      d_s1 <= d_in;
      d_s2 <= d_s1;
      d_s3 <= d_s2;
    end
  end

  assign rise = d_s2 & ~d_s3;

  // Effective byte count: 0 means 1, anything above BURST_MAX is clamped.
  always_comb begin
    len_eff = len;
    if (len == '0)                    len_eff = LW'(1);
    else if (len > LW'(BURST_MAX))    len_eff = LW'(BURST_MAX);
  end

  // Index of the final transmitted byte: cmd+addr, plus data for writes.
  always_comb begin
    bidx_last = rw_q ? BW'(1) : (BW'(len_q) + BW'(1));
  end

  // Byte currently being transmitted: cmd, addr, then write data bytes.
  always_comb begin
    tx_byte = 8'h00;
    if (bidx == '0)            tx_byte = rw_q ? 8'h0C : 8'h0B;
    else if (bidx == BW'(1))   tx_byte = addr_q;
    else begin
      for (int i = 0; i < BURST_MAX; i++) begin
        if (bidx == BW'(i + 2)) tx_byte = wdata_q[8*i +: 8];
      end
    end
  end

  // Main transaction FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      status  <= 2'd0;
      rdata   <= '0;
      d_out   <= 1'b0;
      d_oe    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      len_q   <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      tmr     <= '0;
      ucnt    <= '0;
      fbit    <= 4'd0;
      bidx    <= '0;
      rx_idx  <= '0;
      rx_run  <= 1'b0;
      rx_sh   <= 9'd0;
      st_q    <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          d_oe  <= 1'b0;
          d_out <= 1'b0;
          if (start) begin
            rw_q    <= rw;
            addr_q  <= addr;
            len_q   <= len_eff;
            wdata_q <= wdata;
            rbuf    <= '0;
            busy    <= 1'b1;
            d_oe    <= 1'b1;
            d_out   <= 1'b1;
            tmr     <= '0;
            state   <= S_MPING;
          end
        end

        // Line stays high; the first TX bit (start) is high as well.
        S_MPING: begin
          if (tmr == TW'(PING_CYC - 1)) begin
            tmr   <= '0;
            ucnt  <= '0;
            fbit  <= 4'd0;
            bidx  <= '0;
            state <= S_TX;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        S_TX: begin
          if (ucnt == UW'(CLK_PER_UI - 1)) begin
            ucnt <= '0;
            if (fbit == 4'd10) begin
              fbit <= 4'd0;
              if (bidx == bidx_last) begin
                d_oe  <= 1'b0;
                d_out <= 1'b0;
                tmr   <= '0;
                state <= S_TURN;
              end else begin
                bidx  <= bidx + BW'(1);
                d_out <= 1'b1;
              end
            end else begin
              fbit  <= fbit + 4'd1;
              d_out <= frame_bit(tx_byte, fbit + 4'd1);
            end
          end else begin
            ucnt <= ucnt + UW'(1);
          end
        end

        // Wait for the slave ping to begin; the edge cycle is high cycle 0.
        S_TURN: begin
          if (rise) begin
            tmr   <= TW'(1);
            state <= S_SPING;
          end else if (tmr == TW'(TO_CYC - 1)) begin
            status <= 2'd2;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        // tmr holds the number of high cycles seen before the current one.
        S_SPING: begin
          if (d_s2) begin
            if (tmr == TW'(SP_MAX)) begin
              status <= 2'd2;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end else if (tmr < TW'(SP_MIN)) begin
            status <= 2'd2;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end else begin
            tmr    <= '0;
            rx_run <= 1'b0;
            rx_idx <= '0;
            state  <= S_RX;
          end
        end

        // ucnt/fbit track time since the start edge: fbit = whole UIs elapsed.
        S_RX: begin
          if (!rx_run) begin
            if (rise) begin
              rx_run <= 1'b1;
              ucnt   <= UW'(1);
              fbit   <= 4'd0;
            end else if (tmr == TW'(TO_CYC - 1)) begin
              status <= 2'd2;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end else begin
            if (ucnt == UW'(HALF_UI) && fbit != 4'd0 && fbit <= 4'd9) begin
              rx_sh <= {rx_sh[7:0], d_s2};
            end
            if (ucnt == UW'(CLK_PER_UI - 1)) begin
              ucnt <= '0;
              if (fbit == 4'd10) begin
                // End of the stop UI: judge the byte just received.
                rx_run <= 1'b0;
                tmr    <= '0;
                fbit   <= 4'd0;
                if (rx_sh[0] != ~(^rx_sh[8:1])) begin
                  status <= 2'd3;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
                end else if (!rw_q) begin
                  st_q  <= (rx_sh[8:1] == 8'h08) ? 2'd0 : 2'd1;
                  d_oe  <= 1'b1;
                  d_out <= 1'b1;
                  state <= S_EPING;
                end else begin
                  for (int i = 0; i < BURST_MAX; i++) begin
                    if (rx_idx == LW'(i)) rbuf[8*i +: 8] <= rx_sh[8:1];
                  end
                  if (rx_idx == len_q - LW'(1)) begin
                    st_q  <= 2'd0;
                    d_oe  <= 1'b1;
                    d_out <= 1'b1;
                    state <= S_EPING;
                  end else begin
                    rx_idx <= rx_idx + LW'(1);
                  end
                end
              end else begin
                fbit <= fbit + 4'd1;
              end
            end else begin
              ucnt <= ucnt + UW'(1);
            end
          end
        end

        S_EPING: begin
          if (tmr == TW'(PING_CYC - 1)) begin
            d_oe   <= 1'b0;
            d_out  <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            status <= st_q;
            if (rw_q && st_q == 2'd0) rdata <= rbuf;
            state  <= S_DONE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        // done is high during this cycle; start here is not sampled.
        S_DONE: begin
          d_oe  <= 1'b0;
          d_out <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
